resilient_delay_tuner: RTL and testbench

//   Clocked supervisor for a chain of N error-detecting resilient stage controllers.
//   - Counts per-stage Err0/Err1 events over a programmable window.
//   - Raises or lowers each stage's delay-line select code to keep the error rate inside [lo, hi].
//   - Sits beside the asynchronous pipeline. The stage error flags arrive already synchronised to clk.
//

---
 rtl/resilient_delay_tuner_pkg.sv | 14 +
 rtl/resilient_delay_tuner_if.sv | 29 ++
 rtl/resilient_delay_tuner_err_window_counter.sv | 29 ++
 rtl/resilient_delay_tuner.sv | 178 +++++++++++++++++
 tb/tb_resilient_delay_tuner.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/resilient_delay_tuner_pkg.sv
// Shared definitions for the resilient delay tuner: FSM state encoding and code step sizes.
package resilient_delay_tuner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_ADJUST  = 2'd2,
        ST_SETTLE  = 2'd3
    } state_t;

    localparam int URG_STEP = 2;
    localparam int STEP     = 1;

endpackage

// File: rtl/resilient_delay_tuner_if.sv
// Control/status bundle between the tuner and its host: enable, error flags, thresholds and codes.
interface resilient_delay_tuner_if #(
    parameter int N_STAGES = 2,
    parameter int CODE_W   = 4,
    parameter int CNT_W    = 6,
    parameter int WIN_W    = 8
);
    logic                         en;
    logic [N_STAGES-1:0]          err0;
    logic [N_STAGES-1:0]          err1;
    logic [WIN_W-1:0]             cfg_window;
    logic [CNT_W-1:0]             cfg_hi_thr;
    logic [CNT_W-1:0]             cfg_lo_thr;
    logic [N_STAGES*CODE_W-1:0]   dly_code;
    logic                         dly_code_vld;
    logic                         busy;
    logic [N_STAGES-1:0]          sat_flag;

    modport master (
        output en, err0, err1, cfg_window, cfg_hi_thr, cfg_lo_thr,
        input  dly_code, dly_code_vld, busy, sat_flag
    );

    modport slave (
        input  en, err0, err1, cfg_window, cfg_hi_thr, cfg_lo_thr,
        output dly_code, dly_code_vld, busy, sat_flag
    );

endinterface

// File: rtl/resilient_delay_tuner_err_window_counter.sv
// Per-stage saturating error counter with a sticky urgent bit; clr wins over inc/urg.
module err_window_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             urg,
    output logic [CNT_W-1:0] count,
    output logic             urgent
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            urgent <= 1'b0;
        end else if (clr) begin
            count  <= '0;
            urgent <= 1'b0;
        end else begin
            if (inc && (count != {CNT_W{1'b1}}))
                count <= count + CNT_W'(1);
            if (urg)
                urgent <= 1'b1;
        end
    end

endmodule

// File: rtl/resilient_delay_tuner.sv
// Supervisor that measures per-stage error counts over a window and steers each delay-line code.
//   state      | meaning
//   ST_IDLE    | tuning disabled, codes retained
//   ST_MEASURE | counting errors over the window (early exit on severe error)
//   ST_ADJUST  | one cycle: compute and register new codes
//   ST_SETTLE  | codes stable, error inputs ignored
module resilient_delay_tuner
    import resilient_delay_tuner_pkg::*;
#(
    parameter int N_STAGES = 2,
    parameter int CODE_W   = 4,
    parameter int CNT_W    = 6,
    parameter int WIN_W    = 8,
    parameter int DLY_INIT = 4,
    parameter int DLY_MIN  = 1,
    parameter int SETTLE   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    resilient_delay_tuner_if.slave bus
);

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CODE_W-1:0] CODE_MAX  = {CODE_W{1'b1}};
    localparam logic [CODE_W-1:0] CODE_INIT = CODE_W'(DLY_INIT);
    localparam logic [CODE_W-1:0] CODE_MIN  = CODE_W'(DLY_MIN);
    localparam logic [CODE_W-1:0] URG_INC   = CODE_W'(URG_STEP);
    localparam logic [CODE_W-1:0] STEP_INC  = CODE_W'(STEP);
    localparam logic [SET_W-1:0]  SET_LOAD  = SET_W'(SETTLE - 1);

    state_t state, state_nxt;

    logic [WIN_W-1:0]                win_cnt;
    logic [SET_W-1:0]                set_cnt;
    logic [CNT_W-1:0]                hi_q;
    logic [CNT_W-1:0]                lo_q;
    logic                            load_win;
    logic                            load_set;
    logic                            cnt_clr;
    logic                            do_adjust;
    logic                            measuring;
    logic                            early;
    logic [N_STAGES-1:0]             inc;
    logic [N_STAGES-1:0]             urg;
    logic [N_STAGES-1:0]             urgent;
    logic [N_STAGES-1:0]             changed;
    logic [N_STAGES-1:0]             sat_hit;
    logic [N_STAGES-1:0][CNT_W-1:0]  cnt;
    logic [N_STAGES-1:0][CODE_W-1:0] code_q;
    logic [N_STAGES-1:0][CODE_W-1:0] code_adj;
    logic [N_STAGES-1:0]             sat_q;
    logic                            vld_q;

    assign measuring = (state == ST_MEASURE) && bus.en;
    assign inc       = {N_STAGES{measuring}} & (bus.err0 | bus.err1);
    assign urg       = {N_STAGES{measuring}} & bus.err1;
    // An urgent bit can only be set by the severe error that also ends the window.
    assign early     = |urgent;

    for (genvar g = 0; g < N_STAGES; g++) begin : g_stage
        err_window_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .clr    (cnt_clr),
            .inc    (inc[g]),
            .urg    (urg[g]),
            .count  (cnt[g]),
            .urgent (urgent[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_win  = 1'b0;
        load_set  = 1'b0;
        cnt_clr   = 1'b0;
        do_adjust = 1'b0;
        if (!bus.en) begin
            state_nxt = ST_IDLE;
            cnt_clr   = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_MEASURE;
                    load_win  = 1'b1;
                    cnt_clr   = 1'b1;
                end
                ST_MEASURE: begin
                    if ((|bus.err1) || (|urgent) || (win_cnt == '0))
                        state_nxt = ST_ADJUST;
                end
                ST_ADJUST: begin
                    do_adjust = 1'b1;
                    cnt_clr   = 1'b1;
                    load_set  = 1'b1;
                    state_nxt = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (set_cnt == '0) begin
                        state_nxt = ST_MEASURE;
                        load_win  = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Thresholds are captured with the window so a host update mid-window has no effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt <= '0;
            set_cnt <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            if (load_win) begin
                win_cnt <= (bus.cfg_window == '0) ? '0 : bus.cfg_window - WIN_W'(1);
                hi_q    <= bus.cfg_hi_thr;
                lo_q    <= bus.cfg_lo_thr;
            end else if ((state == ST_MEASURE) && (win_cnt != '0)) begin
                win_cnt <= win_cnt - WIN_W'(1);
            end
            if (load_set)
                set_cnt <= SET_LOAD;
            else if ((state == ST_SETTLE) && (set_cnt != '0))
                set_cnt <= set_cnt - SET_W'(1);
        end
    end

    // An inverted threshold pair holds every non-urgent stage, even when the count is low.
    always_comb begin
        code_adj = code_q;
        changed  = '0;
        sat_hit  = '0;
        for (int i = 0; i < N_STAGES; i++) begin
            if (urgent[i]) begin
                code_adj[i] = (code_q[i] >= CODE_MAX - URG_INC) ? CODE_MAX : code_q[i] + URG_INC;
            end else if (!early && (lo_q <= hi_q)) begin
                if (cnt[i] > hi_q)
                    code_adj[i] = (code_q[i] >= CODE_MAX - STEP_INC) ? CODE_MAX : code_q[i] + STEP_INC;
                else if (cnt[i] < lo_q)
                    code_adj[i] = (code_q[i] > CODE_MIN) ? code_q[i] - STEP_INC : code_q[i];
            end
            changed[i] = (code_adj[i] != code_q[i]);
            sat_hit[i] = changed[i] && (code_adj[i] == CODE_MAX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q <= {N_STAGES{CODE_INIT}};
            vld_q  <= 1'b0;
            sat_q  <= '0;
        end else begin
            vld_q <= do_adjust && (|changed);
            if (do_adjust)
                code_q <= code_adj;
            if (!bus.en)
                sat_q <= '0;
            else if (do_adjust)
                sat_q <= sat_q | sat_hit;
        end
    end

    assign bus.dly_code     = code_q;
    assign bus.dly_code_vld = vld_q;
    assign bus.busy         = (state != ST_IDLE);
    assign bus.sat_flag     = sat_q;

endmodule

// File: tb/tb_resilient_delay_tuner.sv
// Directed bench for the delay tuner: window tuning, urgent exits, saturation, settle masking, enable/reset.
module tb_resilient_delay_tuner;

    localparam int N_STAGES = 2;
    localparam int CODE_W   = 4;
    localparam int CNT_W    = 6;
    localparam int WIN_W    = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   lat;
    bit   found;

    resilient_delay_tuner_if #(
        .N_STAGES(N_STAGES), .CODE_W(CODE_W), .CNT_W(CNT_W), .WIN_W(WIN_W)
    ) tb_if ();

    resilient_delay_tuner #(
        .N_STAGES(N_STAGES), .CODE_W(CODE_W), .CNT_W(CNT_W), .WIN_W(WIN_W),
        .DLY_INIT(4), .DLY_MIN(1), .SETTLE(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (tb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_vld(input int limit, output int cycles, output bit seen);
        seen   = 1'b0;
        cycles = 0;
        for (int i = 1; i <= limit && !seen; i++) begin
            step(1);
            if (tb_if.dly_code_vld === 1'b1) begin
                seen   = 1'b1;
                cycles = i;
            end
        end
    endtask

    // One severe error on stage 1 in the first window cycle; entered and left in SETTLE cycle 1.
    task automatic urgent_hit();
        step(4);
        tb_if.err1 = 2'b10;
        step(1);
        tb_if.err1 = 2'b00;
        step(1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst               = 1'b1;
        tb_if.en          = 1'b0;
        tb_if.err0        = '0;
        tb_if.err1        = '0;
        tb_if.cfg_window  = 8'd16;
        tb_if.cfg_hi_thr  = 6'd3;
        tb_if.cfg_lo_thr  = 6'd1;
        #1;
        check("rst_code", tb_if.dly_code, 32'h44);
        check("rst_vld",  tb_if.dly_code_vld, 32'h0);
        check("rst_busy", tb_if.busy, 32'h0);
        check("rst_sat",  tb_if.sat_flag, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1);

        // Quiet window: both stages lower by one.
        tb_if.en = 1'b1;
        wait_vld(40, lat, found);
        check("quiet_found", 32'(found), 32'h1);
        check("quiet_lat",   32'(lat), 32'd18);
        check("quiet_code",  tb_if.dly_code, 32'h33);
        check("quiet_busy",  tb_if.busy, 32'h1);
        step(1);
        check("quiet_vld_pulse", tb_if.dly_code_vld, 32'h0);
        check("quiet_settle_code", tb_if.dly_code, 32'h33);

        tb_if.en = 1'b0;
        step(1);
        check("dis_busy", tb_if.busy, 32'h0);
        check("dis_code_kept", tb_if.dly_code, 32'h33);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        check("rst2_code", tb_if.dly_code, 32'h44);

        // Four late-data errors on stage 0 only.
        tb_if.en = 1'b1;
        step(1);
        for (int k = 0; k < 4; k++) begin
            tb_if.err0 = 2'b01;
            step(1);
            tb_if.err0 = 2'b00;
            step(1);
        end
        wait_vld(40, lat, found);
        check("late_found", 32'(found), 32'h1);
        check("late_lat",   32'(lat), 32'd9);
        check("late_code",  tb_if.dly_code, 32'h35);

        tb_if.en = 1'b0;
        step(1);
        rst = 1'b1;
        #1;
        rst = 1'b0;

        // Severe error on stage 1 in window cycle 5.
        tb_if.en = 1'b1;
        step(5);
        tb_if.err1 = 2'b10;
        step(1);
        tb_if.err1 = 2'b00;
        check("urg_adj_code", tb_if.dly_code, 32'h44);
        check("urg_adj_vld",  tb_if.dly_code_vld, 32'h0);
        check("urg_adj_busy", tb_if.busy, 32'h1);
        step(1);
        check("urg_code", tb_if.dly_code, 32'h64);
        check("urg_vld",  tb_if.dly_code_vld, 32'h1);

        // Drive stage 1 up to saturation.
        for (int k = 0; k < 4; k++) urgent_hit();
        check("climb_code", tb_if.dly_code, 32'hE4);
        check("climb_sat",  tb_if.sat_flag, 32'h0);
        urgent_hit();
        check("sat_code", tb_if.dly_code, 32'hF4);
        check("sat_vld",  tb_if.dly_code_vld, 32'h1);
        check("sat_flag", tb_if.sat_flag, 32'h2);
        urgent_hit();
        check("sat_hold_code", tb_if.dly_code, 32'hF4);
        check("sat_hold_vld",  tb_if.dly_code_vld, 32'h0);
        check("sat_hold_flag", tb_if.sat_flag, 32'h2);

        // Errors during SETTLE must not count: quiet window lowers both stages.
        tb_if.err0 = 2'b11;
        step(4);
        tb_if.err0 = 2'b00;
        wait_vld(40, lat, found);
        check("settle_found", 32'(found), 32'h1);
        check("settle_lat",   32'(lat), 32'd17);
        check("settle_code",  tb_if.dly_code, 32'hE3);
        check("settle_sat",   tb_if.sat_flag, 32'h2);

        // Disable mid-MEASURE.
        step(7);
        tb_if.en = 1'b0;
        step(1);
        check("off_busy", tb_if.busy, 32'h0);
        check("off_code", tb_if.dly_code, 32'hE3);
        check("off_sat",  tb_if.sat_flag, 32'h0);
        check("off_vld",  tb_if.dly_code_vld, 32'h0);

        // Asynchronous reset while busy.
        tb_if.en = 1'b1;
        step(2);
        check("pre_rst_busy", tb_if.busy, 32'h1);
        rst = 1'b1;
        #2;
        check("mid_rst_code", tb_if.dly_code, 32'h44);
        check("mid_rst_busy", tb_if.busy, 32'h0);
        check("mid_rst_vld",  tb_if.dly_code_vld, 32'h0);
        check("mid_rst_sat",  tb_if.sat_flag, 32'h0);
        tb_if.en = 1'b0;
        rst = 1'b0;

        // Window of zero behaves as one cycle.
        tb_if.cfg_window = 8'd0;
        tb_if.en = 1'b1;
        wait_vld(20, lat, found);
        check("win0_found", 32'(found), 32'h1);
        check("win0_lat",   32'(lat), 32'd3);
        check("win0_code",  tb_if.dly_code, 32'h33);
        tb_if.en = 1'b0;
        step(1);
        rst = 1'b1;
        #1;
        rst = 1'b0;

        // Inverted thresholds hold the codes.
        tb_if.cfg_lo_thr = 6'd5;
        tb_if.cfg_hi_thr = 6'd3;
        tb_if.en = 1'b1;
        step(3);
        check("inv_busy", tb_if.busy, 32'h1);
        check("inv_vld",  tb_if.dly_code_vld, 32'h0);
        check("inv_code", tb_if.dly_code, 32'h44);
        tb_if.en = 1'b0;
        step(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
